// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths and arbiter state encoding
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner select, search starts at ptr+1
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    // Distance of index j from the slot just after ptr; the smallest requesting
    // distance wins. The 2*N bias keeps the operand positive for any ptr value.
    function automatic int rr_dist(input int j, input int p);
        return (j + 2 * N - 1 - p) % N;
    endfunction

    int best;

    always_comb begin
        best  = N;
        gnt   = '0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (rr_dist(j, int'(ptr)) < best)) begin
                best = rr_dist(j, int'(ptr));
            end
        end
        valid = (best < N);
        for (int j = 0; j < N; j++) begin
            gnt[j] = req[j] && (rr_dist(j, int'(ptr)) == best);
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone B4 classic arbiter with per-cycle ack watchdog
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = WB_ADDR_W,
    parameter int DATA_W      = WB_DATA_W,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    output logic [DATA_W-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [ADDR_W-1:0]                 s_adr_o,
    output logic [DATA_W-1:0]                 s_dat_o,
    output logic [DATA_W/8-1:0]               s_sel_o,
    output logic                              s_we_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    input  logic [DATA_W-1:0]                 s_dat_i,
    input  logic                              s_ack_i,
    output logic [NUM_MASTERS-1:0]            gnt_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e             state, state_n;
    logic [NUM_MASTERS-1:0] gnt, gnt_n;
    logic [PTR_W-1:0]       ptr, ptr_n;
    logic [CNT_W-1:0]       wd_cnt, wd_cnt_n;

    logic [NUM_MASTERS-1:0] pick;
    logic                   pick_valid;
    logic [PTR_W-1:0]       pick_idx;
    logic                   busy;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   wd_hit;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (m_cyc_i),
        .ptr   (ptr),
        .gnt   (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (pick[k]) begin
                pick_idx = PTR_W'(k);
            end
        end
    end

    assign busy = (state == ARB_BUSY);

    // Slave-side mux; everything is forced to zero outside BUSY so reset and
    // the idle gap present a quiet bus.
    always_comb begin
        g_cyc   = 1'b0;
        g_stb   = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (busy && gnt[k]) begin
                g_cyc   = m_cyc_i[k];
                g_stb   = m_stb_i[k];
                s_adr_o = m_adr_i[k*ADDR_W +: ADDR_W];
                s_dat_o = m_dat_i[k*DATA_W +: DATA_W];
                s_sel_o = m_sel_i[k*SEL_W +: SEL_W];
                s_we_o  = m_we_i[k];
            end
        end
    end

    assign s_cyc_o = g_cyc;
    assign s_stb_o = g_stb;

    // Fires during the wait cycle that would bring the counter to TIMEOUT.
    assign wd_hit = (TIMEOUT != 0) && busy && g_stb && !s_ack_i &&
                    (wd_cnt == CNT_W'(TIMEOUT - 1));

    assign m_ack_o = gnt & {NUM_MASTERS{busy & s_ack_i}};
    assign m_err_o = gnt & {NUM_MASTERS{wd_hit}};
    assign m_dat_o = busy ? s_dat_i : '0;
    assign gnt_o   = gnt;

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        ptr_n    = ptr;
        wd_cnt_n = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_n = ARB_BUSY;
                    gnt_n   = pick;
                    ptr_n   = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (!g_cyc) begin
                    state_n = ARB_IDLE;
                    gnt_n   = '0;
                end else if ((TIMEOUT != 0) && g_stb && !s_ack_i && !wd_hit) begin
                    wd_cnt_n = wd_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ARB_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ARB_IDLE;
            gnt    <= '0;
            ptr    <= PTR_W'(NUM_MASTERS - 1);
            wd_cnt <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            ptr    <= ptr_n;
            wd_cnt <= wd_cnt_n;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - randomized self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;
    import wb_pkg::*;

    localparam int N   = 3;
    localparam int AW  = WB_ADDR_W;
    localparam int DW  = WB_DATA_W;
    localparam int SW  = WB_SEL_W;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack, m_err, gnt;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o, s_dat_i;
    logic [SW-1:0]   s_sel;
    logic            s_we, s_cyc, s_stb, s_ack;

    logic [AW-1:0] adr [N];
    logic [DW-1:0] dat [N];
    logic [SW-1:0] sel [N];
    logic [N-1:0]  we, cyc, stb;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            m_adr[k*AW +: AW] = adr[k];
            m_dat[k*DW +: DW] = dat[k];
            m_sel[k*SW +: SW] = sel[k];
        end
    end
    assign m_we  = we;
    assign m_cyc = cyc;
    assign m_stb = stb;

    wb_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .s_adr_o (s_adr),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel),
        .s_we_o  (s_we),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack),
        .gnt_o   (gnt)
    );

    function automatic logic [31:0] mem_init(input int i);
        return 32'h1122_3344 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Slave stub: 64-word RAM, one wait cycle per strobe, no ack when hang is set
    logic [31:0] mem [64];
    logic        ack_r;
    logic        hang = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= mem_init(i);
        end else begin
            ack_r <= s_cyc && s_stb && !ack_r && !hang;
            if (s_cyc && s_stb && s_we && ack_r) begin
                for (int b = 0; b < SW; b++) begin
                    if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                end
            end
        end
    end
    assign s_ack   = ack_r;
    assign s_dat_i = mem[s_adr[7:2]];

    int total = 0;
    int bad   = 0;

    int owner, last, wc;
    int cyc_no = 0;
    int beats [N];
    int linger [N];
    bit got_ack [N];
    bit got_err [N];
    int raise_at [N];
    int ack_cnt [N];
    int err_cnt [N];
    int first_ack [N];
    int last_ack [N];
    logic [31:0] rd_last [N];
    logic [31:0] rd1q [$];
    int gseq [$];
    int err_at, scyc_at;
    logic [N-1:0] prev_gnt;
    logic prev_scyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = N - 1;
        wc    = 0;
        for (int k = 0; k < N; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; dat[k] = '0; sel[k] = '0;
            beats[k] = 0; linger[k] = 0; got_ack[k] = 0; got_err[k] = 0;
        end
        prev_gnt  = '0;
        prev_scyc = 1'b0;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < N; k++) begin
            ack_cnt[k] = 0; err_cnt[k] = 0; first_ack[k] = -1; last_ack[k] = -1;
            raise_at[k] = 0; rd_last[k] = '0;
        end
        err_at  = -1;
        scyc_at = -1;
        rd1q.delete();
        gseq.delete();
    endtask

    task automatic start_job(input int k, input int nb, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s);
        beats[k] = nb;
        adr[k]   = a;
        we[k]    = w;
        dat[k]   = d;
        sel[k]   = s;
    endtask

    // One clock: masters react to last cycle's ack/err, then outputs are checked
    // against the arbitration rules and the reference state advances.
    task automatic step();
        logic [N-1:0]  eg, ea, ee;
        logic          ecyc, estb, ewe, waiting;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat, emd;
        logic [SW-1:0] esel;
        @(negedge clk);
        cyc_no++;
        for (int k = 0; k < N; k++) begin
            if (cyc[k]) begin
                if (got_err[k]) begin
                    stb[k] = 1'b0; beats[k] = 0; linger[k] = 2;
                end else if (got_ack[k]) begin
                    beats[k]--;
                    if (beats[k] == 0) begin
                        cyc[k] = 1'b0; stb[k] = 1'b0;
                    end else begin
                        adr[k] = adr[k] + 32'd4;
                    end
                end else if (!stb[k]) begin
                    if (linger[k] > 0) linger[k]--;
                    else cyc[k] = 1'b0;
                end
            end else if (beats[k] > 0) begin
                cyc[k] = 1'b1; stb[k] = 1'b1; raise_at[k] = cyc_no;
            end
        end
        #1;
        eg = '0; ea = '0; ee = '0; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
        eadr = '0; edat = '0; esel = '0; emd = '0; waiting = 1'b0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ecyc = cyc[owner]; estb = stb[owner]; ewe = we[owner];
            eadr = adr[owner]; edat = dat[owner]; esel = sel[owner];
            emd  = s_dat_i;
            if (s_ack) ea[owner] = 1'b1;
            waiting = stb[owner] && !s_ack;
            if (waiting && (wc + 1 == TMO)) ee[owner] = 1'b1;
        end
        chk("gnt",   64'(gnt),     64'(eg));
        chk("s_cyc", 64'(s_cyc),   64'(ecyc));
        chk("s_stb", 64'(s_stb),   64'(estb));
        chk("s_we",  64'(s_we),    64'(ewe));
        chk("s_adr", 64'(s_adr),   64'(eadr));
        chk("s_dat", 64'(s_dat_o), 64'(edat));
        chk("s_sel", 64'(s_sel),   64'(esel));
        chk("m_ack", 64'(m_ack),   64'(ea));
        chk("m_err", 64'(m_err),   64'(ee));
        chk("m_dat", 64'(m_dat_o), 64'(emd));
        for (int k = 0; k < N; k++) begin
            got_ack[k] = m_ack[k];
            got_err[k] = m_err[k];
            if (m_ack[k]) begin
                ack_cnt[k]++;
                rd_last[k] = m_dat_o;
                if (first_ack[k] < 0) first_ack[k] = cyc_no;
                last_ack[k] = cyc_no;
                if (k == 1 && !we[1]) rd1q.push_back(m_dat_o);
            end
            if (m_err[k]) begin
                err_cnt[k]++;
                err_at = cyc_no;
            end
        end
        if (s_cyc && !prev_scyc) scyc_at = cyc_no;
        prev_scyc = s_cyc;
        if (prev_gnt == '0 && gnt != '0) begin
            for (int k = 0; k < N; k++) if (gnt[k]) gseq.push_back(k);
        end
        prev_gnt = gnt;
        if (owner < 0) begin
            wc = 0;
            for (int i = 1; i <= N; i++) begin
                if (owner < 0 && cyc[(last + i) % N]) begin
                    owner = (last + i) % N;
                    last  = owner;
                end
            end
        end else if (!cyc[owner]) begin
            owner = -1;
            wc    = 0;
        end else if (waiting) begin
            wc = (wc + 1 == TMO) ? 0 : wc + 1;
        end else begin
            wc = 0;
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < max) begin
            step();
            n++;
            pend = 1'b0;
            for (int k = 0; k < N; k++) if (cyc[k] || beats[k] > 0) pend = 1'b1;
        end
        chk({tag, "_drain"}, 64'(pend), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc_no, 0);
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        model_reset();
        clear_stats();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt",   64'(gnt),     64'd0);
        chk("rst_s_cyc", 64'(s_cyc),   64'd0);
        chk("rst_s_stb", 64'(s_stb),   64'd0);
        chk("rst_m_ack", 64'(m_ack),   64'd0);
        chk("rst_m_err", 64'(m_err),   64'd0);
        chk("rst_m_dat", 64'(m_dat_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single write from master 0
        clear_stats();
        start_job(0, 1, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        run_idle("t1", 20);
        chk("t1_latency", 64'(scyc_at - raise_at[0]), 64'd1);
        chk("t1_acks",    64'(ack_cnt[0]), 64'd1);
        chk("t1_ram",     64'(mem[4]), 64'hDEAD_BEEF);

        // simultaneous pairs alternate starting with master 0
        do_reset();
        clear_stats();
        for (int r = 0; r < 10; r++) begin
            start_job(0, 1, 32'h40 + 32'(8 * r), 1'b1, $urandom, 4'hF);
            start_job(1, 1, 32'h44 + 32'(8 * r), 1'b1, $urandom, 4'hF);
            run_idle("t2", 40);
        end
        chk("t2_count", 64'(gseq.size()), 64'd20);
        for (int i = 0; i < gseq.size() && i < 20; i++)
            chk($sformatf("t2_order%0d", i), 64'(gseq[i]), 64'(i % 2));

        // master 1 burst read holds the bus against master 0
        clear_stats();
        start_job(1, 4, 32'h0, 1'b0, 32'h0, 4'hF);
        step();
        start_job(0, 1, 32'h80, 1'b0, 32'h0, 4'hF);
        run_idle("t3", 60);
        chk("t3_acks1", 64'(ack_cnt[1]), 64'd4);
        chk("t3_acks0", 64'(ack_cnt[0]), 64'd1);
        chk("t3_after", 64'(first_ack[0] > last_ack[1]), 64'd1);
        chk("t3_nrd",   64'(rd1q.size()), 64'd4);
        for (int i = 0; i < rd1q.size() && i < 4; i++)
            chk($sformatf("t3_rd%0d", i), 64'(rd1q[i]), 64'(mem_init(i)));

        // unresponsive slave trips the watchdog once, grant held until cyc drops
        clear_stats();
        hang = 1'b1;
        start_job(0, 1, 32'h30, 1'b0, 32'h0, 4'hF);
        run_idle("t4", 60);
        hang = 1'b0;
        chk("t4_nerr", 64'(err_cnt[0]), 64'd1);
        chk("t4_when", 64'(err_at - raise_at[0]), 64'(TMO));
        chk("t4_noack", 64'(ack_cnt[0]), 64'd0);

        // random traffic from all masters
        clear_stats();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!cyc[k] && beats[k] == 0 && $urandom_range(0, 3) == 0)
                    start_job(k, int'($urandom_range(1, 3)), 32'($urandom_range(0, 63)) << 2,
                              1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)));
            end
            step();
        end
        run_idle("t5", 400);

        // reset in the middle of a granted cycle
        hang = 1'b1;
        start_job(1, 1, 32'h0, 1'b0, 32'h0, 4'hF);
        n = 0;
        while (!gnt[1] && n < 10) begin
            step();
            n++;
        end
        chk("t6_granted", 64'(gnt[1]), 64'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_s_cyc", 64'(s_cyc), 64'd0);
        chk("t6_gnt",   64'(gnt),   64'd0);
        chk("t6_m_ack", 64'(m_ack), 64'd0);
        chk("t6_m_err", 64'(m_err), 64'd0);
        model_reset();
        hang = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        start_job(1, 1, 32'h10, 1'b0, 32'h0, 4'hF);
        start_job(0, 1, 32'h14, 1'b0, 32'h0, 4'hF);
        run_idle("t6", 40);
        chk("t6_count", 64'(gseq.size()), 64'd2);
        if (gseq.size() > 0) chk("t6_first", 64'(gseq[0]), 64'd0);

        // byte write through master 1, read back through master 0
        start_job(1, 1, 32'h20, 1'b1, 32'h0000_AB00, 4'h2);
        run_idle("t7w", 20);
        start_job(0, 1, 32'h20, 1'b0, 32'h0, 4'hF);
        run_idle("t7r", 20);
        chk("t7_byte", 64'(rd_last[0]), 64'((mem_init(8) & 32'hFFFF_00FF) | 32'h0000_AB00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
